// File: rtl/sample_player.sv
// sample_player: streaming audio playback stage behind the PSRAM controller.
//
// Fetches consecutive 16-bit signed samples from cellular RAM through a
// req/ack read port and buffers them in a small FIFO. One sample is released
// to the audio path on every sample-rate tick.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start, stop     one-cycle pulses: begin playback / abort playback
//   loop_en         wrap back to base_addr after the last sample
//   base_addr       first sample word address (latched on start)
//   length          number of samples (latched on start)
//   mem_req         read request, held until mem_ack
//   mem_addr        read word address, stable while mem_req is high
//   mem_ack         one-cycle pulse: mem_rdata valid, request complete
//   mem_rdata       read data from RAM
//   busy            playback active
//   sample_out      current sample (signed)
//   sample_valid    one-cycle pulse on each tick that pops a sample
//   underrun        sticky flag: a tick found the FIFO empty while fetching
//   pwm_out         PWM audio output
//
// Build option:
//   SAMPLE_PLAYER_PWM_EN  when defined, pwm_out carries an 8-bit PWM of the
//                         current sample; otherwise pwm_out is tied low.

module sample_player #(
  parameter int ADDR_W     = 23,
  parameter int SAMPLE_DIV = 2268,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              underrun,
  output logic              pwm_out
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int TICK_W = $clog2(SAMPLE_DIV);

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [ADDR_W-1:0] ONE_WORD  = ADDR_W'(1);

  // STOP_WAIT: a stop arrived while a read was outstanding; the RAM side
  // cannot abort, so we wait for the ack and throw the data away.
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    STOP_WAIT
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] base_lat;
  logic [ADDR_W-1:0] len_lat;

  logic [15:0]       fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [TICK_W-1:0] tick_cnt;

  logic ack_ok;
  logic start_ok;
  logic abort;
  logic push;
  logic pop;
  logic starve;
  logic last_word;
  logic tick;
  logic playing;

  assign busy      = (state != IDLE);
  assign ack_ok    = mem_req & mem_ack;
  assign start_ok  = (state == IDLE) & start & ~stop & (length != '0);
  assign abort     = stop & ((state == REQ) | (state == DRAIN));
  assign push      = ack_ok & (state == REQ) & ~stop;
  assign last_word = (remaining == ONE_WORD);
  assign tick      = busy & (tick_cnt == TICK_LAST);
  assign playing   = ((state == REQ) | (state == DRAIN)) & ~stop;
  assign pop       = tick & playing & (count != '0);
  // Running dry in DRAIN is the normal end of playback, not an underrun.
  assign starve    = tick & (state == REQ) & ~stop & (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (stop) begin
          state_next = (mem_req & ~mem_ack) ? STOP_WAIT : IDLE;
        end else if (push & last_word & ~loop_en) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // No pushes happen here, so an empty FIFO means the final sample
        // has already been handed out.
        if (stop | (count == '0)) begin
          state_next = IDLE;
        end
      end
      STOP_WAIT: begin
        if (ack_ok) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request port and address bookkeeping. A request is only raised from a
  // low mem_req, so after an ack there is always at least one idle cycle.
  // The space test counts the slot an outstanding read will fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      ptr       <= '0;
      remaining <= '0;
      base_lat  <= '0;
      len_lat   <= '0;
    end else begin
      if (start_ok) begin
        base_lat  <= base_addr;
        len_lat   <= length;
        ptr       <= base_addr;
        remaining <= length;
      end else if (push) begin
        if (last_word & loop_en) begin
          ptr       <= base_lat;
          remaining <= len_lat;
        end else begin
          ptr       <= ptr + ONE_WORD;
          remaining <= remaining - ONE_WORD;
        end
      end

      if (mem_req) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
        end
      end else if ((state == REQ) & ~stop & (count < DEPTH_C)) begin
        mem_req  <= 1'b1;
        mem_addr <= ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= mem_rdata;
    end
  end

  // FIFO pointers; a new start or an abort flushes any buffered samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start_ok | abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push & ~pop) begin
        count <= count + 1'b1;
      end else if (pop & ~push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sample-rate divider and output register. sample_out keeps its value
  // whenever no pop happens, including through underruns and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (!busy || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      sample_valid <= pop;
      if (pop) begin
        sample_out <= fifo[rd_ptr];
      end

      if (start_ok) begin
        underrun <= 1'b0;
      end else if (starve) begin
        underrun <= 1'b1;
      end
    end
  end

`ifdef SAMPLE_PLAYER_PWM_EN
  logic [7:0] pwm_cnt;
  logic [7:0] duty;

  // Duty is the sample's top byte in offset binary, reloaded only at the
  // start of a PWM period so each period is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) begin
        duty <= {~sample_out[15], sample_out[14:8]};
      end
      pwm_out <= (pwm_cnt < duty);
    end
  end
`else
  assign pwm_out = 1'b0;
`endif

endmodule
